// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: CPU fetch/data ports plus memory-macro port of the unified memory arbiter.
interface unified_mem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              inst_req_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic              inst_gnt_o;
  logic              inst_rvalid_o;
  logic              data_req_i;
  logic              data_we_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [DATA_W-1:0] rdata_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_we_o;
  logic              mem_re_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              stall_o;
  logic [15:0]       conflict_cnt_o;
  modport slave (
    input  inst_req_i, inst_addr_i, data_req_i, data_we_i, data_addr_i, data_wdata_i, mem_rdata_i,
    output inst_gnt_o, inst_rvalid_o, data_gnt_o, data_rvalid_o, rdata_o,
           mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o, stall_o, conflict_cnt_o
  );
  modport master (
    output inst_req_i, inst_addr_i, data_req_i, data_we_i, data_addr_i, data_wdata_i, mem_rdata_i,
    input  inst_gnt_o, inst_rvalid_o, data_gnt_o, data_rvalid_o, rdata_o,
           mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o, stall_o, conflict_cnt_o
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: data-priority arbiter with fetch anti-starvation sharing one pipelined memory port.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_WAIT     = 3
) (
  input logic                   CLK,
  input logic                   RST_n,
  unified_mem_arbiter_if.slave  bus
);
  logic                    inst_req, data_req, inst_win, data_win, rd;
  logic [3:0]              starve_q, starve_d;
  logic [15:0]             conflict_q, conflict_d;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [READ_LATENCY-1:0] vld_q, src_q;
  always_comb begin
    inst_req   = bus.inst_req_i && RST_n;
    data_req   = bus.data_req_i && RST_n;
    inst_win   = inst_req && (!data_req || starve_q == 4'(MAX_WAIT));
    data_win   = data_req && !inst_win;
    rd         = inst_win || (data_win && !bus.data_we_i);
    starve_d   = (inst_req && !inst_win) ? ((starve_q == 4'(MAX_WAIT)) ? starve_q : starve_q + 4'd1) : 4'd0;
    conflict_d = (inst_req && data_req && conflict_q != 16'hFFFF) ? conflict_q + 16'd1 : conflict_q;
  end
  assign bus.inst_gnt_o     = inst_win;
  assign bus.data_gnt_o     = data_win;
  assign bus.mem_re_o       = rd;
  assign bus.mem_we_o       = data_win && bus.data_we_i;
  assign bus.mem_addr_o     = inst_win ? bus.inst_addr_i : data_win ? bus.data_addr_i : addr_q;
  assign bus.mem_wdata_o    = (data_win && bus.data_we_i) ? bus.data_wdata_i : wdata_q;
  assign bus.stall_o        = (inst_req && !inst_win) || (data_req && !data_win);
  assign bus.conflict_cnt_o = conflict_q;
  assign bus.rdata_o        = bus.mem_rdata_i;
  // Tail of the return pipeline lines up with mem_rdata_i; src 1 marks a data-port read.
  assign bus.inst_rvalid_o  = vld_q[READ_LATENCY-1] && !src_q[READ_LATENCY-1];
  assign bus.data_rvalid_o  = vld_q[READ_LATENCY-1] && src_q[READ_LATENCY-1];
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      starve_q   <= '0;
      conflict_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      vld_q      <= '0;
      src_q      <= '0;
    end else begin
      starve_q   <= starve_d;
      conflict_q <= conflict_d;
      addr_q     <= bus.mem_addr_o;
      wdata_q    <= bus.mem_wdata_o;
      vld_q      <= READ_LATENCY'({vld_q, rd});
      src_q      <= READ_LATENCY'({src_q, data_win});
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: scenario tasks plus a return-data scoreboard for unified_mem_arbiter.
module tb_unified_mem_arbiter;
  localparam int LAT = 2;
  localparam int MW  = 3;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLK = ~CLK;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(LAT), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .RST_n(RST_n), .bus(bus)
  );

  typedef struct {logic src; logic [31:0] data; int due;} exp_t;
  exp_t sb[$];
  exp_t e;
  int errors = 0, checks = 0, cyc = 0, s_exp = 0, conf_exp = 0;

  // Memory macro model: word at address a reads as 0xA0 + a, LAT cycles after mem_re_o.
  logic [31:0] rpipe [LAT];
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    rpipe[0] <= bus.mem_re_o ? 32'hA0 + bus.mem_addr_o : 32'h0;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.mem_rdata_i = rpipe[LAT-1];

  always @(negedge CLK) begin
    if (bus.inst_rvalid_o || bus.data_rvalid_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid cyc=%0d inst_rvalid=%b data_rvalid=%b, required no return", cyc, bus.inst_rvalid_o, bus.data_rvalid_o);
      end else begin
        e = sb.pop_front();
        if (bus.data_rvalid_o !== e.src || bus.inst_rvalid_o !== !e.src || bus.rdata_o !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL return cyc=%0d data_rvalid=%b inst_rvalid=%b rdata=%h, required cyc=%0d data_rvalid=%b rdata=%h",
                   cyc, bus.data_rvalid_o, bus.inst_rvalid_o, bus.rdata_o, e.due, e.src, e.data);
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      checks++;
      errors++;
      e = sb.pop_front();
      $display("FAIL missing_return cyc=%0d no rvalid, required src=%b data=%h", cyc, e.src, e.data);
    end
  end

  function automatic logic iwin();
    return bus.inst_req_i && (!bus.data_req_i || s_exp == MW);
  endfunction

  task automatic tick();
    if (RST_n) begin
      if (bus.inst_req_i && bus.data_req_i) conf_exp = (conf_exp == 65535) ? 65535 : conf_exp + 1;
      s_exp = (bus.inst_req_i && !iwin()) ? ((s_exp == MW) ? MW : s_exp + 1) : 0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.inst_req_i = 1'b0;
    bus.data_req_i = 1'b0;
    bus.data_we_i  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (sb.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    bus.inst_req_i = 1'b1; bus.inst_addr_i = 32'h10;
    bus.data_req_i = 1'b1; bus.data_addr_i = 32'h20; bus.data_we_i = 1'b0; bus.data_wdata_i = '0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({bus.inst_gnt_o, bus.data_gnt_o, bus.mem_re_o, bus.mem_we_o, bus.stall_o, bus.inst_rvalid_o, bus.data_rvalid_o} !== 7'b0 ||
        bus.conflict_cnt_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_state gnt=%b/%b re=%b we=%b stall=%b conflict=%h, required all 0", bus.inst_gnt_o, bus.data_gnt_o,
               bus.mem_re_o, bus.mem_we_o, bus.stall_o, bus.conflict_cnt_o);
    end
    @(posedge CLK);
    #1;
    RST_n = 1'b1;
    bus.data_req_i = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.inst_gnt_o !== 1'b1 || bus.mem_re_o !== 1'b1 || bus.mem_addr_o !== 32'h10) begin
      errors++;
      $display("FAIL reset_fetch gnt=%b re=%b addr=%h, required gnt=1 re=1 addr=00000010", bus.inst_gnt_o, bus.mem_re_o, bus.mem_addr_o);
    end
    tick();
    RST_n = 1'b0;
    @(negedge CLK);
    checks++;
    if ({bus.inst_gnt_o, bus.data_gnt_o, bus.mem_re_o, bus.stall_o, bus.inst_rvalid_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_midread gnt=%b re=%b stall=%b rvalid=%b, required all 0", bus.inst_gnt_o, bus.mem_re_o, bus.stall_o, bus.inst_rvalid_o);
    end
    idle();
    tick();
    s_exp = 0;
    conf_exp = 0;
    RST_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.inst_rvalid_o !== 1'b0 || bus.conflict_cnt_o !== 16'h0) begin
        errors++;
        $display("FAIL reset_drop[%0d] inst_rvalid=%b conflict=%h, required 0 and 0000", i, bus.inst_rvalid_o, bus.conflict_cnt_o);
      end
      tick();
    end
  endtask

  task automatic test_fetch_only();
    for (int i = 0; i < 3; i++) begin
      bus.inst_req_i = 1'b1;
      bus.inst_addr_i = i;
      sb.push_back('{1'b0, 32'hA0 + i, cyc + LAT});
      @(negedge CLK);
      checks++;
      if (bus.inst_gnt_o !== 1'b1 || bus.stall_o !== 1'b0 || bus.mem_re_o !== 1'b1 || bus.mem_addr_o !== i) begin
        errors++;
        $display("FAIL fetch_only[%0d] gnt=%b stall=%b re=%b addr=%h, required gnt=1 stall=0 re=1 addr=%h",
                 i, bus.inst_gnt_o, bus.stall_o, bus.mem_re_o, bus.mem_addr_o, i);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_priority();
    logic [31:0] ia = 32'h100, da = 32'h200;
    logic exp_i;
    for (int i = 0; i < 8; i++) begin
      bus.inst_req_i = 1'b1; bus.inst_addr_i = ia;
      bus.data_req_i = 1'b1; bus.data_addr_i = da; bus.data_we_i = 1'b0;
      exp_i = (i % 4 == 3);
      sb.push_back('{!exp_i, 32'hA0 + (exp_i ? ia : da), cyc + LAT});
      @(negedge CLK);
      checks++;
      if (bus.inst_gnt_o !== exp_i || bus.data_gnt_o !== !exp_i || bus.stall_o !== 1'b1 || bus.mem_addr_o !== (exp_i ? ia : da)) begin
        errors++;
        $display("FAIL priority[%0d] inst_gnt=%b data_gnt=%b stall=%b addr=%h, required inst_gnt=%b data_gnt=%b stall=1 addr=%h",
                 i, bus.inst_gnt_o, bus.data_gnt_o, bus.stall_o, bus.mem_addr_o, exp_i, !exp_i, exp_i ? ia : da);
      end
      tick();
      if (exp_i) ia += 4; else da += 4;
    end
    @(negedge CLK);
    checks++;
    if (bus.conflict_cnt_o !== 16'(conf_exp) || conf_exp != 8) begin
      errors++;
      $display("FAIL priority_conflict conflict=%h, required 0008", bus.conflict_cnt_o);
    end
    drain();
  endtask

  task automatic test_write();
    bus.inst_req_i = 1'b1; bus.inst_addr_i = 32'h04;
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b1; bus.data_addr_i = 32'h40; bus.data_wdata_i = 32'hDEADBEEF;
    @(negedge CLK);
    checks++;
    if (bus.mem_we_o !== 1'b1 || bus.mem_re_o !== 1'b0 || bus.mem_addr_o !== 32'h40 || bus.mem_wdata_o !== 32'hDEADBEEF ||
        bus.data_gnt_o !== 1'b1 || bus.inst_gnt_o !== 1'b0 || bus.stall_o !== 1'b1) begin
      errors++;
      $display("FAIL write_c0 we=%b re=%b addr=%h wdata=%h dgnt=%b ignt=%b stall=%b, required we=1 re=0 addr=00000040 wdata=deadbeef dgnt=1 ignt=0 stall=1",
               bus.mem_we_o, bus.mem_re_o, bus.mem_addr_o, bus.mem_wdata_o, bus.data_gnt_o, bus.inst_gnt_o, bus.stall_o);
    end
    tick();
    bus.data_req_i = 1'b0; bus.data_we_i = 1'b0;
    sb.push_back('{1'b0, 32'hA4, cyc + LAT});
    @(negedge CLK);
    checks++;
    if (bus.inst_gnt_o !== 1'b1 || bus.mem_re_o !== 1'b1 || bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 32'h04 || bus.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL write_c1 ignt=%b re=%b we=%b addr=%h stall=%b, required ignt=1 re=1 we=0 addr=00000004 stall=0",
               bus.inst_gnt_o, bus.mem_re_o, bus.mem_we_o, bus.mem_addr_o, bus.stall_o);
    end
    tick();
    drain();
  endtask

  task automatic test_interleave();
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.data_addr_i = 32'h20;
    sb.push_back('{1'b1, 32'hC0, cyc + LAT});
    @(negedge CLK);
    checks++;
    if (bus.data_gnt_o !== 1'b1 || bus.mem_re_o !== 1'b1 || bus.mem_addr_o !== 32'h20) begin
      errors++;
      $display("FAIL interleave_c0 dgnt=%b re=%b addr=%h, required 1 1 00000020", bus.data_gnt_o, bus.mem_re_o, bus.mem_addr_o);
    end
    tick();
    bus.data_req_i = 1'b0;
    bus.inst_req_i = 1'b1; bus.inst_addr_i = 32'h08;
    sb.push_back('{1'b0, 32'hA8, cyc + LAT});
    @(negedge CLK);
    checks++;
    if (bus.inst_gnt_o !== 1'b1 || bus.mem_re_o !== 1'b1 || bus.mem_addr_o !== 32'h08) begin
      errors++;
      $display("FAIL interleave_c1 ignt=%b re=%b addr=%h, required 1 1 00000008", bus.inst_gnt_o, bus.mem_re_o, bus.mem_addr_o);
    end
    tick();
    drain();
  endtask

  task automatic test_saturation();
    force dut.conflict_q = 16'hFFFE;
    #1;
    release dut.conflict_q;
    conf_exp = 65534;
    #1;
    checks++;
    if (bus.conflict_cnt_o !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_preset conflict=%h, required fffe", bus.conflict_cnt_o);
    end
    for (int i = 0; i < 3; i++) begin
      bus.inst_req_i = 1'b1; bus.inst_addr_i = 32'h300;
      bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.data_addr_i = 32'h400 + 4 * i;
      sb.push_back('{!iwin(), 32'hA0 + (iwin() ? bus.inst_addr_i : bus.data_addr_i), cyc + LAT});
      tick();
      @(negedge CLK);
      checks++;
      if (bus.conflict_cnt_o !== 16'hFFFF || conf_exp != 65535) begin
        errors++;
        $display("FAIL sat[%0d] conflict=%h, required ffff", i, bus.conflict_cnt_o);
      end
    end
    drain();
  endtask

  initial begin
    idle();
    bus.inst_addr_i = '0; bus.data_addr_i = '0; bus.data_wdata_i = '0;
    test_reset();
    test_fetch_only();
    test_priority();
    test_write();
    test_interleave();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
